// File: rtl/bus_arb_pkg.sv
// Shared types for the unified instruction/data bus arbiter.
package bus_arb_pkg;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        ARB_IDLE        = 2'd0,
        ARB_LOCKED_INST = 2'd1,
        ARB_LOCKED_DATA = 2'd2
    } arb_state_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWNER_INST) ? OWNER_DATA : OWNER_INST;
    endfunction

    function automatic arb_state_t lock_state(input owner_t o);
        return (o == OWNER_INST) ? ARB_LOCKED_INST : ARB_LOCKED_DATA;
    endfunction

endpackage

// File: rtl/arbiter_owner_fifo.sv
// Owner FIFO: records which master issued each outstanding read, in request order.
module arbiter_owner_fifo
    import bus_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  owner_t owner_in,
    output owner_t owner_out,
    output logic   full,
    output logic   empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    owner_t           slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push, do_pop;

    // A pop on an empty FIFO is ignored; a push on a full FIFO is only legal with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign owner_out = slots[rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // NOTE: slot storage is not reset; the count and pointers alone define which slots are live.
    always_ff @(posedge clock) begin
        if (do_push) slots[wr_ptr] <= owner_in;
    end

endmodule

// File: rtl/unified_bus_arbiter.sv
// Two-master (fetch/data) to one-slave bus arbiter with in-order read response routing.
// Define ARBITER_ROUND_ROBIN_EN for round-robin contention; default is DATA over INST.
module unified_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inst_address,
    input  logic        inst_read_enable,
    output logic        inst_wait_req,
    output logic        inst_valid,
    output logic [31:0] inst_read_data,
    input  logic [31:0] data_address,
    input  logic        data_read_enable,
    input  logic        data_write_enable,
    input  logic [31:0] data_write_data,
    input  logic [3:0]  data_byte_enable,
    output logic        data_wait_req,
    output logic        data_valid,
    output logic [31:0] data_read_data,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_byte_enable,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    input  logic        mem_wait_req,
    input  logic        mem_valid,
    input  logic [31:0] mem_read_data
);
    arb_state_t state, state_next;
    owner_t     grant_owner, priority_owner, head_owner;
    logic       inst_req, data_req, grant_active, grant_read, grant_write;
    logic       read_blocked, accept, fifo_full, fifo_empty, response;

    assign inst_req = inst_read_enable;
    assign data_req = data_read_enable | data_write_enable;

`ifdef ARBITER_ROUND_ROBIN_EN
    owner_t rr_ptr;

    // rr_ptr names the master that wins the next tie: the one not granted last.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      rr_ptr <= OWNER_INST;
        else if (accept) rr_ptr <= other_owner(grant_owner);
    end

    assign priority_owner = rr_ptr;
`else
    assign priority_owner = OWNER_DATA;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_active = 1'b0;
        grant_owner  = OWNER_INST;
        unique case (state)
            ARB_IDLE: begin
                grant_active = inst_req | data_req;
                if (inst_req && data_req) grant_owner = priority_owner;
                else if (data_req)        grant_owner = OWNER_DATA;
            end
            ARB_LOCKED_INST: grant_active = inst_req;
            ARB_LOCKED_DATA: begin
                grant_active = data_req;
                grant_owner  = OWNER_DATA;
            end
            default: ;
        endcase
        if (!reset) grant_active = 1'b0;
    end

    assign grant_read  = grant_active & ((grant_owner == OWNER_INST) ? inst_read_enable
                                                                     : data_read_enable);
    assign grant_write = grant_active & (grant_owner == OWNER_DATA) & data_write_enable;

    // A same-cycle response frees a slot, so a full FIFO only blocks without mem_valid.
    assign read_blocked = grant_read & fifo_full & ~mem_valid;
    assign accept       = grant_active & ~mem_wait_req & ~read_blocked;

    assign mem_read_enable  = grant_read & ~read_blocked;
    assign mem_write_enable = grant_write;
    assign mem_address      = (grant_owner == OWNER_DATA) ? data_address : inst_address;
    assign mem_write_data   = data_write_data;
    assign mem_byte_enable  = (grant_owner == OWNER_DATA) ? data_byte_enable : 4'hF;

    assign inst_wait_req = ~(grant_active && grant_owner == OWNER_INST) | mem_wait_req | read_blocked;
    assign data_wait_req = ~(grant_active && grant_owner == OWNER_DATA) | mem_wait_req | read_blocked;

    always_comb begin
        state_next = ARB_IDLE;
        if (grant_active && !accept) state_next = lock_state(grant_owner);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ARB_IDLE;
        else        state <= state_next;
    end

    arbiter_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_owner_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (accept & grant_read),
        .pop       (reset & mem_valid),
        .owner_in  (grant_owner),
        .owner_out (head_owner),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign response       = reset & mem_valid & ~fifo_empty;
    assign inst_valid     = response & (head_owner == OWNER_INST);
    assign data_valid     = response & (head_owner == OWNER_DATA);
    assign inst_read_data = mem_read_data;
    assign data_read_data = mem_read_data;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset && mem_valid)
            assert (!fifo_empty) else $warning("mem_valid with no outstanding read");
    end
`endif

endmodule

// File: tb/tb_unified_bus_arbiter.sv
// Bench for unified_bus_arbiter: directed scenarios plus random traffic against a queue model.
module tb_unified_bus_arbiter;
    localparam int MAX_OUTSTANDING = 2;
`ifdef ARBITER_ROUND_ROBIN_EN
    localparam int FIRST = 0;
`else
    localparam int FIRST = 1;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] inst_address;
    logic        inst_read_enable;
    logic        inst_wait_req, inst_valid;
    logic [31:0] inst_read_data;
    logic [31:0] data_address, data_write_data;
    logic        data_read_enable, data_write_enable;
    logic [3:0]  data_byte_enable;
    logic        data_wait_req, data_valid;
    logic [31:0] data_read_data;
    logic [31:0] mem_address, mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_read_enable, mem_write_enable;
    logic        mem_wait_req, mem_valid;
    logic [31:0] mem_read_data;

    unified_bus_arbiter #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) dut (
        .clock(clock), .reset(reset),
        .inst_address(inst_address), .inst_read_enable(inst_read_enable),
        .inst_wait_req(inst_wait_req), .inst_valid(inst_valid), .inst_read_data(inst_read_data),
        .data_address(data_address), .data_read_enable(data_read_enable),
        .data_write_enable(data_write_enable), .data_write_data(data_write_data),
        .data_byte_enable(data_byte_enable), .data_wait_req(data_wait_req),
        .data_valid(data_valid), .data_read_data(data_read_data),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_byte_enable(mem_byte_enable), .mem_read_enable(mem_read_enable),
        .mem_write_enable(mem_write_enable), .mem_wait_req(mem_wait_req),
        .mem_valid(mem_valid), .mem_read_data(mem_read_data)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Model: -1 = nobody, 0 = INST, 1 = DATA.
    int oq[$];
    int lock = -1;
    int last_gnt = 1;
    int m_g, m_resp;
    bit m_read, m_blocked, m_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit ireq, dreq;
        ireq = inst_read_enable;
        dreq = data_read_enable || data_write_enable;
        m_g = -1;
        if (reset) begin
            if (lock >= 0)
                m_g = ((lock == 0 && ireq) || (lock == 1 && dreq)) ? lock : -1;
            else if (ireq && dreq)
`ifdef ARBITER_ROUND_ROBIN_EN
                m_g = (last_gnt == 0) ? 1 : 0;
`else
                m_g = 1;
`endif
            else if (dreq) m_g = 1;
            else if (ireq) m_g = 0;
        end
        m_read    = (m_g == 0) || (m_g == 1 && data_read_enable);
        m_blocked = m_read && oq.size() == MAX_OUTSTANDING && !mem_valid;
        m_acc     = m_g >= 0 && !mem_wait_req && !m_blocked;
        m_resp    = (reset && mem_valid && oq.size() > 0) ? oq[0] : -1;
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    task automatic settle();
        bit exp_we;
        #1;
        model_eval();
        exp_we = (m_g == 1) && data_write_enable;
        check("mem_read_enable", 32'(mem_read_enable), 32'(m_read && !m_blocked));
        check("mem_write_enable", 32'(mem_write_enable), 32'(exp_we));
        check("inst_wait_req", 32'(inst_wait_req), 32'(m_g != 0 || mem_wait_req || m_blocked));
        check("data_wait_req", 32'(data_wait_req), 32'(m_g != 1 || mem_wait_req || m_blocked));
        check("inst_valid", 32'(inst_valid), 32'(m_resp == 0));
        check("data_valid", 32'(data_valid), 32'(m_resp == 1));
        if ((m_read && !m_blocked) || exp_we)
            check("mem_address", mem_address, (m_g == 1) ? data_address : inst_address);
        if (exp_we) begin
            check("mem_write_data", mem_write_data, data_write_data);
            check("mem_byte_enable", 32'(mem_byte_enable), 32'(data_byte_enable));
        end
        if (m_resp == 0) check("inst_read_data", inst_read_data, mem_read_data);
        if (m_resp == 1) check("data_read_data", data_read_data, mem_read_data);
    endtask

    task automatic advance();
        @(posedge clock);
        if (!reset) begin
            lock = -1;
            oq.delete();
            last_gnt = 1;
        end else begin
            if (mem_valid && oq.size() > 0) void'(oq.pop_front());
            if (m_acc && m_read) oq.push_back(m_g);
            if (m_acc) begin
                last_gnt = m_g;
                lock = -1;
            end else begin
                lock = m_g;
            end
        end
        @(negedge clock);
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    initial begin
        int acc_g;
        reset = 1'b0;
        inst_address = '0; inst_read_enable = 1'b1;
        data_address = '0; data_read_enable = 1'b1; data_write_enable = 1'b0;
        data_write_data = '0; data_byte_enable = '0;
        mem_wait_req = 1'b0; mem_valid = 1'b0; mem_read_data = '0;
        @(negedge clock);

        // Reset held with both masters requesting.
        settle();
        check("rst_mem_re", 32'(mem_read_enable), 32'h0);
        check("rst_inst_wait", 32'(inst_wait_req), 32'h1);
        check("rst_data_wait", 32'(data_wait_req), 32'h1);
        advance();

        // Single fetch and its response.
        reset = 1'b1; data_read_enable = 1'b0; inst_address = 32'h100;
        settle();
        check("t1_addr", mem_address, 32'h100);
        check("t1_inst_wait", 32'(inst_wait_req), 32'h0);
        advance();
        inst_read_enable = 1'b0; mem_valid = 1'b1; mem_read_data = 32'h13;
        settle();
        check("t1_inst_valid", 32'(inst_valid), 32'h1);
        check("t1_inst_data", inst_read_data, 32'h13);
        check("t1_data_valid", 32'(data_valid), 32'h0);
        advance();
        mem_valid = 1'b0;

        // Contention after a fresh reset.
        reset = 1'b0; cycle(); reset = 1'b1;
        inst_read_enable = 1'b1; inst_address = 32'h0;
        data_read_enable = 1'b1; data_address = 32'h2000;
        settle();
        check("t2_first_addr", mem_address, (FIRST == 0) ? 32'h0 : 32'h2000);
        advance();
        if (FIRST == 0) inst_read_enable = 1'b0; else data_read_enable = 1'b0;
        settle();
        check("t2_second_addr", mem_address, (FIRST == 0) ? 32'h2000 : 32'h0);
        advance();
        inst_read_enable = 1'b0; data_read_enable = 1'b0;
        mem_valid = 1'b1; mem_read_data = 32'hAAAA;
        settle();
        check("t2_r1_inst_valid", 32'(inst_valid), 32'(FIRST == 0));
        check("t2_r1_data_valid", 32'(data_valid), 32'(FIRST == 1));
        advance();
        mem_read_data = 32'hBBBB;
        settle();
        check("t2_r2_inst_valid", 32'(inst_valid), 32'(FIRST == 1));
        check("t2_r2_data", (FIRST == 0) ? data_read_data : inst_read_data, 32'hBBBB);
        advance();
        mem_valid = 1'b0;

        // Stalled write holds the bus while the fetch waits.
        data_write_enable = 1'b1; data_address = 32'h2004;
        data_byte_enable = 4'b0011; data_write_data = 32'hCAFEF00D; mem_wait_req = 1'b1;
        cycle();
        inst_read_enable = 1'b1; inst_address = 32'h300;
        for (int k = 0; k < 2; k++) begin
            settle();
            check("t3_hold_we", 32'(mem_write_enable), 32'h1);
            check("t3_hold_be", 32'(mem_byte_enable), 32'h3);
            check("t3_inst_wait", 32'(inst_wait_req), 32'h1);
            advance();
        end
        mem_wait_req = 1'b0;
        settle();
        check("t3_accept_addr", mem_address, 32'h2004);
        check("t3_accept_inst_wait", 32'(inst_wait_req), 32'h1);
        advance();
        data_write_enable = 1'b0;
        cycle();
        inst_read_enable = 1'b0; mem_valid = 1'b1; mem_read_data = 32'h1234;
        settle();
        check("t3_inst_valid", 32'(inst_valid), 32'h1);
        advance();
        mem_valid = 1'b0;

        // Owner FIFO full: third read blocked until a same-cycle response.
        inst_read_enable = 1'b1; inst_address = 32'h400; cycle();
        inst_address = 32'h404; cycle();
        inst_address = 32'h408;
        settle();
        check("t4_blocked_re", 32'(mem_read_enable), 32'h0);
        check("t4_blocked_wait", 32'(inst_wait_req), 32'h1);
        advance();
        cycle();
        mem_valid = 1'b1; mem_read_data = 32'h55;
        settle();
        check("t4_pushpop_re", 32'(mem_read_enable), 32'h1);
        check("t4_pushpop_wait", 32'(inst_wait_req), 32'h0);
        advance();
        mem_valid = 1'b0; inst_address = 32'h40C;
        settle();
        check("t4_still_full_re", 32'(mem_read_enable), 32'h0);
        advance();
        mem_valid = 1'b1; cycle();
        inst_read_enable = 1'b0; cycle(); cycle();
        mem_valid = 1'b0;

        // Reset mid-transfer with one read outstanding, then a stray response.
        inst_read_enable = 1'b1; inst_address = 32'h500; cycle();
        inst_read_enable = 1'b0; reset = 1'b0;
        settle();
        check("t5_rst_inst_wait", 32'(inst_wait_req), 32'h1);
        advance();
        reset = 1'b1; mem_valid = 1'b1; mem_read_data = 32'h77;
        settle();
        check("t5_stray_inst_valid", 32'(inst_valid), 32'h0);
        check("t5_stray_data_valid", 32'(data_valid), 32'h0);
        advance();
        mem_valid = 1'b0;

        // Random traffic; masters hold each request until accepted.
        for (int c = 0; c < 3000; c++) begin
            if (!inst_read_enable && $urandom_range(0, 1) == 1) begin
                inst_read_enable = 1'b1;
                inst_address = $urandom;
            end
            if (!data_read_enable && !data_write_enable && $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 1) == 1) data_read_enable = 1'b1;
                else                            data_write_enable = 1'b1;
                data_address = $urandom;
                data_write_data = $urandom;
                data_byte_enable = 4'($urandom);
            end
            mem_wait_req = ($urandom_range(0, 3) == 0);
            mem_valid = (oq.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_read_data = $urandom;
            settle();
            acc_g = m_acc ? m_g : -1;
            advance();
            if (acc_g == 0) inst_read_enable = 1'b0;
            if (acc_g == 1) begin
                data_read_enable = 1'b0;
                data_write_enable = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unified_bus_arbiter.md
# unified_bus_arbiter

Two-master, one-slave arbiter that lets the core's instruction-fetch port and data port share a single memory bus using the codebase's read_enable / write_enable / wait_req / valid handshake. It sits between `riscv_core` and one unified memory bus in place of separate text and data memories. It holds a grant until the slave accepts the transfer. It tracks outstanding reads in an owner FIFO so in-order read responses (`valid` plus read data) return to the correct master.

## Interface
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered reads; power of two, ≥1.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; arbiter is in reset while 0.
- inst_address  in  32  fetch address.
- inst_read_enable  in  1  fetch request (read only).
- inst_wait_req  out  1  fetch not accepted this cycle.
- inst_valid  out  1  fetch data valid.
- inst_read_data  out  32  fetch data.
- data_address  in  32  data address.
- data_read_enable / data_write_enable  in  1 each  data request; never both high.
- data_write_data  in  32  store data.
- data_byte_enable  in  4  store byte lanes.
- data_wait_req  out  1  data request not accepted.
- data_valid  out  1  load data valid.
- data_read_data  out  32  load data.
- mem_address, mem_write_data, mem_byte_enable  out  32/32/4  to slave.
- mem_read_enable, mem_write_enable  out  1 each  to slave.
- mem_wait_req  in  1  slave stalls the presented request.
- mem_valid  in  1  slave read response valid, in request order.
- mem_read_data  in  32  slave read data.

## Operation
- Acceptance rule, all ports: a request is accepted in a cycle where its enable is high and its wait_req is low. A master holds its address, data and enables stable until acceptance.
- Grant states: IDLE (no lock) and LOCKED_INST / LOCKED_DATA.
  - In IDLE the arbiter picks a winner among active requesters and drives that winner's signals to `mem_*` combinationally in the same cycle.
  - If `mem_wait_req`=1, it moves to the LOCKED state of the winner and keeps that grant until `mem_wait_req`=0 with the enable still high. It then returns to IDLE.
- Non-granted master: wait_req=1. Granted master: wait_req = `mem_wait_req` | read_blocked.
- read_blocked: the owner FIFO is full and the granted request is a read. When read_blocked is set, `mem_read_enable` is forced to 0 and the grant is held.
- Each accepted read pushes its owner (INST/DATA) into the owner FIFO. Writes push nothing and produce no `valid`.
- On `mem_valid`=1 the FIFO head is popped. `mem_read_data` and the valid pulse go to the head owner only. The other master's valid is 0 and its read data is don't-care (driven with `mem_read_data`).
- Push and pop in the same cycle: occupancy is unchanged. This is legal when the FIFO is full, because the pop frees the slot first, so read_blocked is computed as full & ~mem_valid.
- `mem_valid` with an empty FIFO is a protocol error. It is ignored and no valid is issued. Under simulation only, an assertion fires.
- Reset: state IDLE, FIFO empty, round-robin pointer = INST. While reset=0, all `mem_*` enables = 0, both wait_req = 1, and both valid = 0.

## Timing
- Request path is zero-latency combinational: master to `mem_*` in the same cycle. Accepted in the cycle `mem_wait_req`=0.
- Response path is combinational: `mem_valid` to `<owner>_valid` in the same cycle. Added latency is 0.
- FIFO and grant state update on the rising clock edge. Reset acts asynchronously on assertion; release is synchronised externally.
- Grant switch: the non-winner can be accepted no earlier than the cycle after the winner's acceptance (one arbitration per cycle).

## Configuration
- ARBITER_ROUND_ROBIN_EN defined: on contention in IDLE, the master not granted last wins. The pointer toggles on every acceptance.
- Not defined: fixed priority, DATA over INST; no pointer register. Fetch starvation is acceptable because the core stalls fetch while waiting on data.

## Structure
- Shared package `bus_arb_pkg`:
  - enum owner_t {OWNER_INST, OWNER_DATA}
  - enum arb_state_t {ARB_IDLE, ARB_LOCKED_INST, ARB_LOCKED_DATA}
- Sub-module `arbiter_owner_fifo`:
  - parameter DEPTH.
  - push/pop/owner_in/owner_out/full/empty.
  - Pointer-based, with an occupancy counter of width clog2(DEPTH)+1.

## Test plan
- Reset held 0 with both masters requesting → `mem_read_enable`=0, both wait_req=1. Release, inst read @0x100, `mem_wait_req`=0 → accepted same cycle. `mem_valid` one cycle later with 0x00000013 → inst_valid=1, inst_read_data=0x13, data_valid=0.
- Simultaneous inst read @0x0 and data read @0x2000, slave always ready → round-robin grants INST then DATA in consecutive cycles. Responses 0xAAAA then 0xBBBB go to inst then data. With the macro undefined, DATA goes first.
- Data write @0x2004, byte_enable 4'b0011, `mem_wait_req`=1 for 3 cycles while inst requests → `mem_*` holds the write for 3 cycles and inst_wait_req=1 throughout. FIFO is unchanged and no valid is issued.
- MAX_OUTSTANDING=2, two inst reads accepted with no response → the third read is blocked (`mem_read_enable`=0). With `mem_valid` in the same cycle as the third request → it is accepted, and occupancy stays at 2.
- Reset asserted mid-transfer with 1 read outstanding → the FIFO clears immediately. A later stray `mem_valid` produces no master valid.
